// File: rtl/sub_pkg.sv
// Shared arithmetic constants for the pipelined subtract datapath.
// Later arithmetic blocks reuse these to get the same operand width and slicing.
// No logic here.
package sub_pkg;

  localparam int SUB_WIDTH  = 64;                     // operand width
  localparam int SUB_SLICE  = 16;                     // bits resolved per pipeline stage
  localparam int SUB_STAGES = SUB_WIDTH / SUB_SLICE;  // pipeline depth (4)

endpackage

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder slice: four 4-bit groups with a lookahead across the groups.
// Purely combinational, zero latency.
// No flow control; the enclosing pipeline registers the result.
module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [15:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate for each 4-bit block
  always_comb begin
    gg = '0;
    gp = '0;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
  end

  // Second-level lookahead: carry into every group directly from cin
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  // In-group carries, each expanded from its group carry-in
  always_comb begin
    c = '0;
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];

endmodule

// File: rtl/sub_64_pipe.sv
// 64-bit subtractor a - b - bin; one 16-bit CLA slice per stage, with results accumulated low to high.
// Latency is 4 cycles from accept to out_valid. Throughput is one beat per cycle.
// Backpressure uses a single global enable (!out_valid || out_ready) that freezes every stage; in_ready equals that enable.
module sub_64_pipe
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int SLICE = SUB_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  // Width of the operand bits still unresolved after each stage
  localparam int W1 = WIDTH - SLICE;
  localparam int W2 = WIDTH - 2 * SLICE;
  localparam int W3 = WIDTH - 3 * SLICE;

  logic                  en;
  logic [SUB_STAGES-1:0] vld;

  // Slice outputs; stage 0 works straight off the input port
  logic [SLICE-1:0] s0, s1, s2, s3;
  logic             c0, c1, c2, c3;

  // Inter-stage registers: carry, finished low diff bits, remaining a and ~b bits
  logic               cy1_q, cy2_q, cy3_q;
  logic [SLICE-1:0]   d1_q;
  logic [2*SLICE-1:0] d2_q;
  logic [3*SLICE-1:0] d3_q;
  logic [W1-1:0]      a1_q, nb1_q;
  logic [W2-1:0]      a2_q, nb2_q;
  logic [W3-1:0]      a3_q, nb3_q;

  // A full output register stalls everything, so the input sees the stall the same cycle
  assign en        = !vld[SUB_STAGES-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld[SUB_STAGES-1];

  // Subtraction is a + ~b + ~bin; the inverted borrow-in is the first carry
  cla_16 u_slice0 (.a(a[SLICE-1:0]),    .b(~b[SLICE-1:0]),    .cin(~bin),  .sum(s0), .cout(c0));
  cla_16 u_slice1 (.a(a1_q[SLICE-1:0]), .b(nb1_q[SLICE-1:0]), .cin(cy1_q), .sum(s1), .cout(c1));
  cla_16 u_slice2 (.a(a2_q[SLICE-1:0]), .b(nb2_q[SLICE-1:0]), .cin(cy2_q), .sum(s2), .cout(c2));
  cla_16 u_slice3 (.a(a3_q),            .b(nb3_q),            .cin(cy3_q), .sum(s3), .cout(c3));

  // Valid shift register: bubbles travel as zeros, and everything holds when en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (en) begin
      vld <= {vld[SUB_STAGES-2:0], in_valid};
    end
  end

  // Stage 1 register: result of slice 0 plus the upper operand bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cy1_q <= 1'b0;
      d1_q  <= '0;
      a1_q  <= '0;
      nb1_q <= '0;
    end else if (en) begin
      cy1_q <= c0;
      d1_q  <= s0;
      a1_q  <= a[WIDTH-1:SLICE];
      nb1_q <= ~b[WIDTH-1:SLICE];
    end
  end

  // Stage 2 register: slice 1 result appended above slice 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cy2_q <= 1'b0;
      d2_q  <= '0;
      a2_q  <= '0;
      nb2_q <= '0;
    end else if (en) begin
      cy2_q <= c1;
      d2_q  <= {s1, d1_q};
      a2_q  <= a1_q[W1-1:SLICE];
      nb2_q <= nb1_q[W1-1:SLICE];
    end
  end

  // Stage 3 register: only the top slice of operands remains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cy3_q <= 1'b0;
      d3_q  <= '0;
      a3_q  <= '0;
      nb3_q <= '0;
    end else if (en) begin
      cy3_q <= c2;
      d3_q  <= {s2, d2_q};
      a3_q  <= a2_q[W2-1:SLICE];
      nb3_q <= nb2_q[W2-1:SLICE];
    end
  end

  // Output register: full diff, borrow is the inverted final carry, and overflow from the sign bits
  // (a[63] != b[63] is the same as a[63] == ~b[63])
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (en) begin
      diff <= {s3, d3_q};
      bout <= ~c3;
      ovf  <= (a3_q[W3-1] == nb3_q[W3-1]) && (s3[SLICE-1] != a3_q[W3-1]);
    end
  end

endmodule

// File: tb/tb_sub_64_pipe.sv
// Directed and randomized bench for sub_64_pipe.
// Inputs are driven at negedge and outputs are sampled 1ns later; the posedge performs the transfer.
// Results are checked against hand-computed vectors and a behavioural subtract model.
module tb_sub_64_pipe;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] diff;
  logic        bout;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  sub_64_pipe u_dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain 65-bit subtraction, with bit 64 as the borrow
  function automatic logic [65:0] model(input logic [63:0] av, input logic [63:0] bv, input logic bi);
    logic [64:0] full;
    logic        ov;
    full = {1'b0, av} - {1'b0, bv} - {64'd0, bi};
    ov   = (av[63] != bv[63]) && (full[63] != av[63]);
    return {full[64], ov, full[63:0]};
  endfunction

  task automatic test_reset;
    rst = 1'b0; a = '0; b = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if ({bout, ovf, diff} !== 66'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", {bout, ovf, diff}); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_during got=%b exp=1", in_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
  endtask

  // One isolated beat: accept, then out_valid must stay low for 3 cycles and rise in the 4th
  task automatic run_vector(input string name, input logic [63:0] av, input logic [63:0] bv,
                            input logic bi, input logic [63:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    a = av; b = bv; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_accept in_ready=%b exp=1", name, in_ready); end
    @(negedge clk);
    in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early cycle=%0d out_valid=%b exp=0", name, k, out_valid); end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_latency out_valid=%b exp=1", name, out_valid); end
    checks++;
    if (diff !== ed) begin errors++; $display("FAIL %s_diff got=%h exp=%h", name, diff, ed); end
    checks++;
    if ({bout, ovf} !== {eb, eo}) begin errors++; $display("FAIL %s_flags bout/ovf got=%b%b exp=%b%b", name, bout, ovf, eb, eo); end
  endtask

  task automatic test_vectors;
    run_vector("zero_minus_one", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_vector("min_minus_one", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_vector("ones_bin1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_vector("ones_bin0", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b0, 1'b0);
    run_vector("slice_borrow", 64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_vector("max_minus_neg", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
  endtask

  // Six back-to-back beats a=i, b=0, with out_ready low in cycles 5..7
  task automatic test_back_to_back;
    int sent;
    int got;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc <= 7);
      in_valid  = (sent < 6);
      a = 64'(sent + 1); b = '0; bin = 1'b0;
      #1;
      if (cyc >= 5 && cyc <= 7) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready cycle=%0d got=%b exp=0", cyc, in_ready); end
        checks++;
        if ({out_valid, diff} !== {1'b1, 64'd2}) begin
          errors++; $display("FAIL b2b_stall_hold cycle=%0d valid=%b diff=%h exp valid=1 diff=2", cyc, out_valid, diff);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if ({bout, ovf, diff} !== {2'b00, 64'(got + 1)}) begin
          errors++; $display("FAIL b2b_order got=%h exp=%h", {bout, ovf, diff}, {2'b00, 64'(got + 1)});
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    checks++;
    if (got !== 6) begin errors++; $display("FAIL b2b_count got=%0d exp=6", got); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_duplicate out_valid=%b exp=0", out_valid); end
  endtask

  // One beat at the output and three in flight, then reset; nothing stale may emerge
  task automatic test_reset_midflight;
    int stale;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 64'(10 + cyc); b = '0; bin = 1'b0; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_precondition out_valid=%b exp=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_clear out_valid=%b exp=0", out_valid); end
    checks++;
    if ({bout, ovf, diff} !== 66'd0) begin errors++; $display("FAIL midrst_outputs got=%h exp=0", {bout, ovf, diff}); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    run_vector("post_reset", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0);
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (k > 0 && out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL midrst_stale_beats got=%0d exp=0", stale); end
  endtask

  // Random traffic with random stalls, scoreboarded against the model
  task automatic test_random;
    localparam int N = 10000;
    logic [65:0] q[$];
    logic [65:0] exp_v;
    logic [63:0] prev_diff;
    logic        prev_stall;
    int sent;
    int got;
    int cyc;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_diff = '0;
    while ((sent < N || got < sent) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid = (sent < N) && ($urandom_range(0, 3) != 0);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = a;
        1: a = '0;
        2: b = 64'hFFFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      bin = 1'($urandom_range(0, 1));
      out_ready = (sent >= N) || ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++; $display("FAIL rnd_in_ready cycle=%0d got=%b exp=%b", cyc, in_ready, !out_valid || out_ready);
      end
      if (prev_stall) begin
        checks++;
        if ({out_valid, diff} !== {1'b1, prev_diff}) begin
          errors++; $display("FAIL rnd_stall_hold cycle=%0d valid=%b diff=%h exp diff=%h", cyc, out_valid, diff, prev_diff);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected cycle=%0d got=%h exp=no beat", cyc, {bout, ovf, diff});
        end else begin
          exp_v = q.pop_front();
          if ({bout, ovf, diff} !== exp_v) begin
            errors++; $display("FAIL rnd_result cycle=%0d got=%h exp=%h", cyc, {bout, ovf, diff}, exp_v);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, bin));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_diff  = diff;
    end
    checks++;
    if (got !== N || q.size() != 0) begin
      errors++; $display("FAIL rnd_drain got=%0d exp=%0d pending=%0d", got, N, q.size());
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_back_to_back;
    test_reset_midflight;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
